// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter (and its receiver peer).
// Contents:
//   tx_state_e     : transmitter FSM state encoding
//   PARITY_EVEN/ODD: parity-type selector values
//   DATA_WIDTH_DEF : default frame data width
//   cnt_width()    : bit-counter width for a given data width
//   parity_of()    : parity bit for a data word and parity type
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int DATA_WIDTH_DEF = 8;

  // A counter that indexes data_width bits needs at least one bit even
  // when data_width is 1.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Even parity is the XOR of all data bits; odd parity is its inverse,
  // which is the same as XOR-ing in the type bit.
  function automatic logic parity_of(input logic [63:0] data, input logic ptype);
    return (^data) ^ ptype;
  endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// tx_parity_calc: purely combinational parity generator.
// Ports:
//   data        in  data_width  word to protect
//   parity_type in  1           0 = even, 1 = odd
//   parity_bit  out 1           parity bit to append to the frame
module tx_parity_calc
  import uart_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF
) (
  input  logic [data_width-1:0] data,
  input  logic                  parity_type,
  output logic                  parity_bit
);

  logic [63:0] data_ext;

  // Zero-extension does not change the XOR reduction.
  assign data_ext   = 64'(data);
  assign parity_bit = parity_of(data_ext, parity_type);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, one clock per bit period.
// Frame: start (0), data LSB first, optional parity, one stop (1).
// Ports:
//   CLK           in  1           bit clock
//   RST           in  1           asynchronous active-low reset
//   P_DATA        in  data_width  byte to send, sampled on accept
//   Data_valid    in  1           request, accepted only while idle
//   Parity_Enable in  1           insert parity bit (sampled on accept)
//   Parity_Type   in  1           0 = even, 1 = odd (sampled on accept)
//   TX_OUT        out 1           registered serial line, idles high
//   Busy          out 1           registered, high from start through stop
module uart_tx
  import uart_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [data_width-1:0] P_DATA,
  input  logic                  Data_valid,
  input  logic                  Parity_Enable,
  input  logic                  Parity_Type,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CW = cnt_width(data_width);
  localparam logic [CW-1:0] CNT_LAST = CW'(data_width - 1);

  tx_state_e             state, state_next;
  logic [data_width-1:0] shift_reg, shift_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic                  par_bit, par_next;
  logic                  par_en, par_en_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  par_calc;

  tx_parity_calc #(
    .data_width(data_width)
  ) u_parity (
    .data       (P_DATA),
    .parity_type(Parity_Type),
    .parity_bit (par_calc)
  );

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so they change on the same edge as the state.
  always_comb begin
    state_next  = state;
    shift_next  = shift_reg;
    cnt_next    = cnt;
    par_next    = par_bit;
    par_en_next = par_en;
    tx_next     = 1'b1;
    busy_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Data_valid) begin
          state_next  = ST_START;
          shift_next  = P_DATA;
          par_next    = par_calc;
          par_en_next = Parity_Enable;
          cnt_next    = '0;
          tx_next     = 1'b0;
          busy_next   = 1'b1;
        end else begin
          state_next = ST_IDLE;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
        end
      end
      ST_START: begin
        // Present D0 on entry to DATA and pre-shift so shift[0] holds D1.
        state_next = ST_DATA;
        tx_next    = shift_reg[0];
        shift_next = {1'b0, shift_reg[data_width-1:1]};
        cnt_next   = '0;
        busy_next  = 1'b1;
      end
      ST_DATA: begin
        busy_next = 1'b1;
        if (cnt == CNT_LAST) begin
          if (par_en) begin
            state_next = ST_PARITY;
            tx_next    = par_bit;
          end else begin
            state_next = ST_STOP;
            tx_next    = 1'b1;
          end
        end else begin
          state_next = ST_DATA;
          tx_next    = shift_reg[0];
          shift_next = {1'b0, shift_reg[data_width-1:1]};
          cnt_next   = cnt + CW'(1);
        end
      end
      ST_PARITY: begin
        state_next = ST_STOP;
        tx_next    = 1'b1;
        busy_next  = 1'b1;
      end
      ST_STOP: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset leaves the line idle high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      par_bit   <= 1'b0;
      par_en    <= 1'b0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      cnt       <= cnt_next;
      par_bit   <= par_next;
      par_en    <= par_en_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
    end
  end

  assign TX_OUT = tx_reg;
  assign Busy   = busy_reg;

endmodule
